state_dump_unit: RTL and testbench

STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

---
 rtl/cpu_dbg_pkg.sv | 20 ++
 rtl/state_dump_unit_sat_counter.sv | 18 +
 rtl/state_dump_unit.sv | 146 ++++++++++++++
 tb/tb_state_dump_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and frame geometry for the CPU debug state-dump block.
package cpu_dbg_pkg;

  localparam int HDR_WORDS = 4;
  localparam int REG_WORDS = 32;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_REGS = 2'd2,
    ST_MEM  = 2'd3
  } dump_state_e;

  function automatic int frame_words(input int mem_words, input int extra);
    return HDR_WORDS + REG_WORDS + mem_words + extra;
  endfunction

endpackage

// File: rtl/state_dump_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      cnt_o <= '0;
    else if (en_i && (cnt_o != {CNT_W{1'b1}}))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/state_dump_unit.sv
// Streams a snapshot frame (counters, pc, register file, data memory) out a valid/ready port.
// Optional DUMP_CHECKSUM_EN appends an XOR checksum word to every frame.
module state_dump_unit
  import cpu_dbg_pkg::*;
#(
  parameter int MEM_WORDS = 8,
  parameter int CNT_W     = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        dout_last_o,
  output logic        busy_o
);

`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM_WORDS = 1;
`else
  localparam int CSUM_WORDS = 0;
`endif

  localparam int FRAME_WORDS = frame_words(MEM_WORDS, CSUM_WORDS);
  localparam int IDX_W       = $clog2(FRAME_WORDS + 1);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_REGS     = idx_t'(HDR_WORDS);
  localparam idx_t IDX_MEM      = idx_t'(HDR_WORDS + REG_WORDS);
  localparam idx_t IDX_DATA_END = idx_t'(HDR_WORDS + REG_WORDS + MEM_WORDS);
  localparam idx_t IDX_LAST     = idx_t'(FRAME_WORDS - 1);
  localparam idx_t IDX_END      = idx_t'(FRAME_WORDS);

  // cnt[0]=cycles, cnt[1]=stalls, cnt[2]=flushes
  logic [2:0]            cnt_en;
  logic [2:0][CNT_W-1:0] cnt;

  assign cnt_en = {start_i & flush_i, start_i & stall_i, start_i};

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (cnt_en[g]),
      .cnt_o (cnt[g])
    );
  end

  dump_state_e                state_q;
  idx_t                       idx_q;
  idx_t                       idx_nxt;
  word_t [HDR_WORDS-1:0]      hdr_q;
  word_t                      next_word;
  logic                       load;

`ifdef DUMP_CHECKSUM_EN
  word_t csum_q;
`endif

  assign idx_nxt = idx_q + 1'b1;
  assign busy_o  = (state_q != ST_IDLE);

  // The output register refills whenever it is empty or being drained this edge.
  assign load = busy_o && (!dout_valid_o || dout_ready_i) && (idx_q != IDX_END);

  // Addresses track idx_q, which only moves on a load, so they hold under backpressure.
  assign reg_addr_o = (state_q == ST_REGS) ? 5'(idx_q - IDX_REGS) : 5'd0;
  assign mem_addr_o = (state_q == ST_MEM && idx_q < IDX_DATA_END) ?
                      (word_t'(idx_q - IDX_MEM) << 2) : 32'd0;

  always_comb begin
    next_word = '0;
    if (idx_q < IDX_REGS)
      next_word = hdr_q[idx_q[1:0]];
    else if (idx_q < IDX_MEM)
      next_word = reg_data_i;
    else if (idx_q < IDX_DATA_END)
      next_word = mem_data_i;
`ifdef DUMP_CHECKSUM_EN
    else
      next_word = csum_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      hdr_q        <= '0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      dout_last_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dump_req_i) begin
            state_q <= ST_HDR;
            idx_q   <= '0;
            hdr_q   <= {word_t'(cnt[2]), word_t'(cnt[1]), pc_i, word_t'(cnt[0])};
          end
        end
        default: begin
          if (load) begin
            dout_o       <= next_word;
            dout_valid_o <= 1'b1;
            dout_last_o  <= (idx_q == IDX_LAST);
            idx_q        <= idx_nxt;
            if (idx_nxt == IDX_MEM)
              state_q <= ST_MEM;
            else if (idx_nxt == IDX_REGS)
              state_q <= ST_REGS;
          end else if (dout_valid_o && dout_ready_i) begin
            dout_valid_o <= 1'b0;
            dout_last_o  <= 1'b0;
            if (dout_last_o) begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
            end
          end
        end
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      csum_q <= '0;
    else if (state_q == ST_IDLE)
      csum_q <= '0;
    else if (load && idx_q < IDX_DATA_END)
      csum_q <= csum_q ^ next_word;
  end
`endif

endmodule

// File: tb/tb_state_dump_unit.sv
// Randomized bench for state_dump_unit; expected frames come from a spec-level model.
module tb_state_dump_unit;

  localparam int MW = 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int FLEN = 36 + MW + 1;
`else
  localparam int FLEN = 36 + MW;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, flush, dump_req, ready;
  logic [31:0] pc;
  logic [4:0]  reg_addr, reg_addr_s;
  logic [31:0] reg_data, reg_data_s, mem_addr, mem_addr_s, mem_data, mem_data_s;
  logic [31:0] dout, dout_s;
  logic        dout_valid, dout_last, busy, dout_valid_s, dout_last_s, busy_s;

  logic [31:0] regs [32];
  logic [31:0] mem  [MW];

  assign reg_data   = regs[reg_addr];
  assign reg_data_s = regs[reg_addr_s];
  assign mem_data   = (mem_addr   < 32'(MW*4)) ? mem[mem_addr[4:2]]   : 32'hDEAD_BEEF;
  assign mem_data_s = (mem_addr_s < 32'(MW*4)) ? mem[mem_addr_s[4:2]] : 32'hDEAD_BEEF;

  state_dump_unit #(.MEM_WORDS(MW), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .dump_req_i(dump_req), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data), .dout_o(dout), .dout_valid_o(dout_valid),
    .dout_ready_i(ready), .dout_last_o(dout_last), .busy_o(busy));

  state_dump_unit #(.MEM_WORDS(MW), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .dump_req_i(dump_req), .reg_addr_o(reg_addr_s), .reg_data_i(reg_data_s),
    .mem_addr_o(mem_addr_s), .mem_data_i(mem_data_s), .dout_o(dout_s), .dout_valid_o(dout_valid_s),
    .dout_ready_i(ready), .dout_last_o(dout_last_s), .busy_o(busy_s));

  int checks = 0;
  int failures = 0;

  // reference model state
  int unsigned m_cyc, m_stl, m_fls;
  bit          m_active = 0, m_end = 0;
  int          m_xfer = 0;
  int          edge_n = 0;
  logic [31:0] snap_c[$], snap_p[$], snap_s[$], snap_f[$];
  int          req_t[$];
  logic [31:0] exp_w[$];

  // collected transfers
  logic [31:0] got_w[$], got_s[$];
  bit          got_l[$];
  int          got_t[$];
  int          busy_falls = 0;
  bit          busy_prev = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cyc = 0; m_stl = 0; m_fls = 0; m_active = 0; m_end = 0; m_xfer = 0;
    end else begin
      if (m_end) begin
        m_active = 0; m_end = 0;
      end else if (dump_req && !m_active) begin
        snap_c.push_back(m_cyc); snap_p.push_back(pc);
        snap_s.push_back(m_stl); snap_f.push_back(m_fls);
        req_t.push_back(edge_n);
        m_active = 1; m_xfer = 0;
      end
      if (start && m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (start && stall && m_stl != 32'hFFFF_FFFF) m_stl++;
      if (start && flush && m_fls != 32'hFFFF_FFFF) m_fls++;
    end
    edge_n++;
  end

  // Mid-cycle: a word is recorded when valid&&ready will be seen by the coming edge.
  always @(negedge clk) begin
    #2;
    if (rst && dout_valid && ready) begin
      got_w.push_back(dout); got_l.push_back(dout_last); got_t.push_back(edge_n);
      if (m_active) begin
        m_xfer++;
        if (m_xfer == FLEN) m_end = 1;
      end
    end
    if (rst && dout_valid_s && ready) got_s.push_back(dout_s);
    if (busy_prev && !busy) busy_falls++;
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_w.size() < n && k < budget) begin tick(1); k++; end
  endtask

  task automatic do_reset();
    rst = 0; start = 0; stall = 0; flush = 0; dump_req = 0; ready = 1;
    tick(2);
    rst = 1;
    got_w.delete(); got_l.delete(); got_t.delete(); got_s.delete();
    snap_c.delete(); snap_p.delete(); snap_s.delete(); snap_f.delete(); req_t.delete();
    busy_falls = 0;
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    pc = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic build_exp(input int k);
    logic [31:0] x;
    exp_w.delete();
    exp_w.push_back(snap_c[k]); exp_w.push_back(snap_p[k]);
    exp_w.push_back(snap_s[k]); exp_w.push_back(snap_f[k]);
    for (int i = 0; i < 32; i++) exp_w.push_back(regs[i]);
    for (int i = 0; i < MW; i++) exp_w.push_back(mem[i]);
`ifdef DUMP_CHECKSUM_EN
    x = 0;
    foreach (exp_w[i]) x ^= exp_w[i];
    exp_w.push_back(x);
`else
    x = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 0; start = 1; stall = 1; flush = 1; dump_req = 1; ready = 0; pc = 32'h1234;
    tick(3);
    dump_req = 0;
    #3;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dout !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (dout_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", dout_last); end
    checks++; if (reg_addr !== 5'd0) begin failures++; $display("FAIL reset_reg_addr got=%h exp=0", reg_addr); end
    checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL reset_busy_sat got=%b exp=0", busy_s); end
    do_reset();
  endtask

  task automatic test_normal_frame();
    logic [9:0] smask, fmask;
    int bad, nlast;
    bit consec;
    do_reset(); randomize_state();
    smask = '0; fmask = '0;
    while ($countones(smask) < 3) smask[$urandom_range(9, 0)] = 1'b1;
    while ($countones(fmask) < 2) fmask[$urandom_range(9, 0)] = 1'b1;
    start = 1;
    for (int i = 0; i < 10; i++) begin stall = smask[i]; flush = fmask[i]; tick(1); end
    start = 0; stall = 0; flush = 0;
    dump_req = 1; tick(1); dump_req = 0;
    wait_words(FLEN, 200); tick(5);
    checks++;
    if (got_w.size() != FLEN || snap_c.size() != 1) begin
      failures++; $display("FAIL normal_len got=%0d exp=%0d", got_w.size(), FLEN);
    end else begin
      build_exp(0);
      checks++; if (got_w[0] !== 32'd10) begin failures++; $display("FAIL normal_cyc got=%0d exp=10", got_w[0]); end
      checks++; if (got_w[1] !== pc) begin failures++; $display("FAIL normal_pc got=%h exp=%h", got_w[1], pc); end
      checks++; if (got_w[2] !== 32'd3) begin failures++; $display("FAIL normal_stl got=%0d exp=3", got_w[2]); end
      checks++; if (got_w[3] !== 32'd2) begin failures++; $display("FAIL normal_fls got=%0d exp=2", got_w[3]); end
      bad = -1; nlast = 0; consec = 1;
      for (int i = 0; i < FLEN; i++) begin
        if (bad < 0 && got_w[i] !== exp_w[i]) bad = i;
        if (got_l[i]) nlast++;
        if (i > 0 && got_t[i] != got_t[i-1] + 1) consec = 0;
      end
      checks++; if (bad >= 0) begin failures++; $display("FAIL normal_word[%0d] got=%h exp=%h", bad, got_w[bad], exp_w[bad]); end
      checks++; if (nlast != 1 || !got_l[FLEN-1]) begin failures++; $display("FAIL normal_last count=%0d on_final=%b exp=1/1", nlast, got_l[FLEN-1]); end
      checks++; if (!consec) begin failures++; $display("FAIL normal_throughput consecutive=%b exp=1", consec); end
      checks++; if (got_t[0] != req_t[0] + 2) begin failures++; $display("FAIL normal_first_edge got=%0d exp=%0d", got_t[0], req_t[0] + 2); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL normal_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset(); randomize_state();
    regs[1] = 32'hAB;
    start = 1;
    for (int i = 0; i < 7; i++) begin stall = 1'($urandom); flush = 1'($urandom); tick(1); end
    dump_req = 1; ready = 1; tick(1); dump_req = 0;
    tick(6);
    ready = 0;
    for (int k = 0; k < 5; k++) begin
      #3;
      checks++; if (dout !== 32'hAB || dout_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] dout=%h valid=%b exp=000000ab/1", k, dout, dout_valid); end
      checks++; if (reg_addr !== 5'd2) begin failures++; $display("FAIL bp_reg_addr[%0d] got=%0d exp=2", k, reg_addr); end
      @(negedge clk);
    end
    ready = 1;
    wait_words(FLEN, 200); tick(5);
    start = 0; stall = 0; flush = 0;
    checks++;
    if (got_w.size() != FLEN || snap_c.size() != 1) begin
      failures++; $display("FAIL bp_len got=%0d exp=%0d", got_w.size(), FLEN);
    end else begin
      build_exp(0);
      bad = -1;
      for (int i = 0; i < FLEN; i++) if (bad < 0 && got_w[i] !== exp_w[i]) bad = i;
      checks++; if (bad >= 0) begin failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", bad, got_w[bad], exp_w[bad]); end
    end
  endtask

  task automatic test_req_during_frame();
    int bad;
    do_reset(); randomize_state();
    start = 1; stall = 1;
    tick($urandom_range(12, 3));
    stall = 0;
    dump_req = 1; tick(1); dump_req = 0;
    tick(10);
    dump_req = 1; tick(1); dump_req = 0;
    wait_words(FLEN, 200); tick(20);
    start = 0;
    checks++; if (got_w.size() != FLEN) begin failures++; $display("FAIL midreq_len got=%0d exp=%0d", got_w.size(), FLEN); end
    checks++; if (busy_falls != 1) begin failures++; $display("FAIL midreq_busy_falls got=%0d exp=1", busy_falls); end
    if (got_w.size() == FLEN && snap_c.size() == 1) begin
      build_exp(0);
      bad = -1;
      for (int i = 0; i < FLEN; i++) if (bad < 0 && got_w[i] !== exp_w[i]) bad = i;
      checks++; if (bad >= 0) begin failures++; $display("FAIL midreq_word[%0d] got=%h exp=%h", bad, got_w[bad], exp_w[bad]); end
    end
  endtask

  task automatic test_random_ready();
    int bad, n, nlast;
    do_reset(); randomize_state();
    for (int i = 0; i < $urandom_range(30, 5); i++) begin
      start = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom); tick(1);
    end
    dump_req = 1;
    n = 0;
    while (got_w.size() < FLEN && n < 1000) begin
      ready = 1'($urandom);
      start = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
      tick(1);
      dump_req = 0;
      n++;
    end
    ready = 1; start = 0; stall = 0; flush = 0;
    tick(5);
    checks++;
    if (got_w.size() != FLEN || snap_c.size() != 1) begin
      failures++; $display("FAIL rand_len got=%0d exp=%0d", got_w.size(), FLEN);
    end else begin
      build_exp(0);
      bad = -1; nlast = 0;
      for (int i = 0; i < FLEN; i++) begin
        if (bad < 0 && got_w[i] !== exp_w[i]) bad = i;
        if (got_l[i]) nlast++;
      end
      checks++; if (bad >= 0) begin failures++; $display("FAIL rand_word[%0d] got=%h exp=%h", bad, got_w[bad], exp_w[bad]); end
      checks++; if (nlast != 1 || !got_l[FLEN-1]) begin failures++; $display("FAIL rand_last count=%0d exp=1", nlast); end
    end
  endtask

  task automatic test_back_to_back();
    int bad, n;
    do_reset(); randomize_state();
    start = 1;
    ready = 1; dump_req = 1;
    n = 0;
    while (got_w.size() < FLEN + 2 && n < 500) begin tick(1); n++; end
    dump_req = 0;
    wait_words(2 * FLEN, 300); tick(10);
    start = 0;
    checks++;
    if (got_w.size() != 2 * FLEN || snap_c.size() != 2) begin
      failures++; $display("FAIL b2b_len got=%0d frames=%0d exp=%0d/2", got_w.size(), snap_c.size(), 2 * FLEN);
    end else begin
      for (int f = 0; f < 2; f++) begin
        build_exp(f);
        bad = -1;
        for (int i = 0; i < FLEN; i++) if (bad < 0 && got_w[f*FLEN+i] !== exp_w[i]) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL b2b_frame%0d_word[%0d] got=%h exp=%h", f, bad, got_w[f*FLEN+bad], exp_w[bad]); end
      end
      checks++; if (got_t[FLEN] - got_t[FLEN-1] != 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", got_t[FLEN] - got_t[FLEN-1]); end
    end
    checks++; if (busy_falls != 2) begin failures++; $display("FAIL b2b_busy_falls got=%0d exp=2", busy_falls); end
  endtask

  task automatic test_mid_frame_reset();
    int bad;
    do_reset(); randomize_state();
    start = 1; stall = 1; flush = 1;
    tick($urandom_range(20, 5));
    dump_req = 1; ready = 1; tick(1); dump_req = 0;
    tick(21);
    rst = 0; tick(1); rst = 1;
    start = 0; stall = 0; flush = 0;
    #3;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", dout_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    tick(10);
    checks++; if (got_w.size() != 20) begin failures++; $display("FAIL rstmid_words got=%0d exp=20", got_w.size()); end
    got_w.delete(); got_l.delete(); got_t.delete();
    dump_req = 1; tick(1); dump_req = 0;
    wait_words(FLEN, 200); tick(5);
    checks++;
    if (got_w.size() != FLEN || snap_c.size() != 2) begin
      failures++; $display("FAIL rstmid_len got=%0d exp=%0d", got_w.size(), FLEN);
    end else begin
      checks++; if (got_w[0] !== 0 || got_w[2] !== 0 || got_w[3] !== 0) begin failures++; $display("FAIL rstmid_counters got=%0d/%0d/%0d exp=0/0/0", got_w[0], got_w[2], got_w[3]); end
      build_exp(1);
      bad = -1;
      for (int i = 0; i < FLEN; i++) if (bad < 0 && got_w[i] !== exp_w[i]) bad = i;
      checks++; if (bad >= 0) begin failures++; $display("FAIL rstmid_word[%0d] got=%h exp=%h", bad, got_w[bad], exp_w[bad]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] sat_c, sat_s;
    do_reset(); randomize_state();
    start = 1; stall = 1; flush = 0;
    tick(20);
    start = 0; stall = 0;
    dump_req = 1; tick(1); dump_req = 0;
    wait_words(FLEN, 200); tick(5);
    checks++;
    if (got_s.size() != FLEN || got_w.size() != FLEN || snap_c.size() != 1) begin
      failures++; $display("FAIL sat_len got=%0d/%0d exp=%0d", got_s.size(), got_w.size(), FLEN);
    end else begin
      sat_c = (snap_c[0] > 15) ? 32'd15 : snap_c[0];
      sat_s = (snap_s[0] > 15) ? 32'd15 : snap_s[0];
      checks++; if (got_s[0] !== sat_c) begin failures++; $display("FAIL sat_cyc got=%h exp=%h", got_s[0], sat_c); end
      checks++; if (got_s[2] !== sat_s) begin failures++; $display("FAIL sat_stl got=%h exp=%h", got_s[2], sat_s); end
      checks++; if (got_s[3] !== 32'd0) begin failures++; $display("FAIL sat_fls got=%h exp=0", got_s[3]); end
      checks++; if (got_w[0] !== snap_c[0] || got_w[2] !== snap_s[0]) begin failures++; $display("FAIL sat_wide got=%0d/%0d exp=%0d/%0d", got_w[0], got_w[2], snap_c[0], snap_s[0]); end
    end
  endtask

`ifdef DUMP_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    for (int i = 0; i < 32; i++) regs[i] = 0;
    for (int i = 0; i < MW; i++) mem[i] = 0;
    regs[8] = 32'd5; mem[0] = 32'd3; pc = 32'h10;
    dump_req = 1; tick(1); dump_req = 0;
    wait_words(FLEN, 200); tick(5);
    checks++;
    if (got_w.size() != 45) begin
      failures++; $display("FAIL csum_len got=%0d exp=45", got_w.size());
    end else begin
      checks++; if (got_w[44] !== 32'h16) begin failures++; $display("FAIL csum_word got=%h exp=00000016", got_w[44]); end
      checks++; if (got_l[44] !== 1'b1 || got_l[43] !== 1'b0) begin failures++; $display("FAIL csum_last got=%b/%b exp=1/0", got_l[44], got_l[43]); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; start = 0; stall = 0; flush = 0; dump_req = 0; ready = 1; pc = 0;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    for (int i = 0; i < MW; i++) mem[i] = 0;
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_req_during_frame();
    test_random_ready();
    test_back_to_back();
    test_mid_frame_reset();
    test_saturation();
`ifdef DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
